// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-transmitter signals shared by the arbiter and its environment.
// The master side drives requests and transmitter status; the slave side is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int OWN_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] data_in;
  logic [NUM_REQ-1:0]   last;
  logic [NUM_REQ-1:0]   ack;
  logic [NUM_REQ-1:0]   grant;
  logic [OWN_W-1:0]     owner_id;
  logic                 tx_start;
  logic [7:0]           tx_byte;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 timeout_err;

  modport master (
    output req, data_in, last, tx_busy, tx_done,
    input  ack, grant, owner_id, tx_start, tx_byte, timeout_err
  );

  modport slave (
    input  req, data_in, last, tx_busy, tx_done,
    output ack, grant, owner_id, tx_start, tx_byte, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter; grant 1 cycle after req, tx_start/ack 1 later.
// Holds in LOAD while tx_busy is high; bursts up to MAX_BURST bytes, then an idle gap.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BR        = 9600,
  parameter int CLK_RATE  = 50_000_000,
  parameter int GAP_BITS  = 2,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int OWN_W   = $clog2(NUM_REQ);
  localparam int BIT_CYC = CLK_RATE / BR;
  localparam int TO_CYC  = 12 * BIT_CYC;
  localparam int GAP_RAW = GAP_BITS * BIT_CYC;
  localparam int GAP_CYC = (GAP_RAW == 0) ? 1 : GAP_RAW;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, GAP} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant, grant_nxt;
  logic [NUM_REQ-1:0] ack, ack_nxt;
  logic [OWN_W-1:0]   owner, owner_nxt;
  logic [OWN_W-1:0]   rr_ptr, rr_nxt;
  logic [3:0]         burst_cnt, burst_nxt;
  logic               last_seen, last_seen_nxt;
  logic [19:0]        timer, timer_nxt;
  logic               tx_start, tx_start_nxt;
  logic [7:0]         tx_byte, tx_byte_nxt;
  logic               timeout_err, timeout_nxt;

  logic [OWN_W-1:0]   win_idx;
  logic [OWN_W:0]     cand;
  logic               found;

  // First pending requester at or after rr_ptr, wrapping around.
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (OWN_W+1)'(i);
      if (cand >= (OWN_W+1)'(NUM_REQ))
        cand = cand - (OWN_W+1)'(NUM_REQ);
      if (!found && bus.req[cand[OWN_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[OWN_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    owner_nxt     = owner;
    rr_nxt        = rr_ptr;
    burst_nxt     = burst_cnt;
    last_seen_nxt = last_seen;
    timer_nxt     = timer;
    ack_nxt       = '0;
    tx_start_nxt  = 1'b0;
    tx_byte_nxt   = tx_byte;
    timeout_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (|bus.req) begin
          grant_nxt          = '0;
          grant_nxt[win_idx] = 1'b1;
          owner_nxt          = win_idx;
          burst_nxt          = '0;
          state_nxt          = LOAD;
        end
      end

      LOAD: begin
        if (!bus.req[owner]) begin
          grant_nxt = '0;
          state_nxt = IDLE;
        end else if (!bus.tx_busy) begin
          tx_start_nxt   = 1'b1;
          tx_byte_nxt    = bus.data_in[{owner, 3'b000} +: 8];
          ack_nxt[owner] = 1'b1;
          last_seen_nxt  = bus.last[owner];
          burst_nxt      = burst_cnt + 4'd1;
          timer_nxt      = '0;
          state_nxt      = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        // tx_done takes precedence over a timeout landing on the same cycle.
        if (bus.tx_done) begin
          if (bus.req[owner] && !last_seen && (burst_cnt < 4'(MAX_BURST))) begin
            state_nxt = LOAD;
          end else begin
            grant_nxt = '0;
            rr_nxt    = (owner == OWN_W'(NUM_REQ-1)) ? '0 : owner + OWN_W'(1);
            timer_nxt = '0;
            state_nxt = GAP;
          end
        end else if (timer == 20'(TO_CYC-1)) begin
          timeout_nxt = 1'b1;
          grant_nxt   = '0;
          rr_nxt      = (owner == OWN_W'(NUM_REQ-1)) ? '0 : owner + OWN_W'(1);
          timer_nxt   = '0;
          state_nxt   = GAP;
        end else begin
          timer_nxt = timer + 20'd1;
        end
      end

      GAP: begin
        if (timer == 20'(GAP_CYC-1))
          state_nxt = IDLE;
        else
          timer_nxt = timer + 20'd1;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      owner       <= '0;
      rr_ptr      <= '0;
      burst_cnt   <= '0;
      last_seen   <= 1'b0;
      timer       <= '0;
      ack         <= '0;
      tx_start    <= 1'b0;
      tx_byte     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      owner       <= owner_nxt;
      rr_ptr      <= rr_nxt;
      burst_cnt   <= burst_nxt;
      last_seen   <= last_seen_nxt;
      timer       <= timer_nxt;
      ack         <= ack_nxt;
      tx_start    <= tx_start_nxt;
      tx_byte     <= tx_byte_nxt;
      timeout_err <= timeout_nxt;
    end
  end

  assign bus.grant       = grant;
  assign bus.ack         = ack;
  assign bus.owner_id    = owner;
  assign bus.tx_start    = tx_start;
  assign bus.tx_byte     = tx_byte;
  assign bus.timeout_err = timeout_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with BIT_CYC=16: 192-cycle timeout, 32-cycle gap.
// Outputs are sampled on the falling edge; inputs change right after sampling.
module tb_uart_tx_arbiter;
  localparam int NR = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus();

  uart_tx_arbiter #(
    .NUM_REQ(NR), .BR(1), .CLK_RATE(16), .GAP_BITS(2), .MAX_BURST(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] data;
    logic        busy;
    logic        done;
    int          n;
    logic [3:0]  e_grant;
    logic [3:0]  e_ack;
    logic        e_start;
    logic [7:0]  e_byte;
    logic [1:0]  e_own;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  task automatic wait_grant(input string name, input int max, output int cnt);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (bus.grant == '0 && cnt < max);
    if (bus.grant == '0) bound_fail(name);
  endtask

  task automatic wait_start(input string name, input int max, output int cnt);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!bus.tx_start && cnt < max);
    if (!bus.tx_start) bound_fail(name);
  endtask

  // Called on the tx_start sample; tx_done is pulsed dly cycles later.
  task automatic finish_frame(input int dly);
    bus.tx_busy = 1'b1;
    repeat (dly) @(negedge clk);
    bus.tx_done = 1'b1;
    bus.tx_busy = 1'b0;
    @(negedge clk);
    bus.tx_done = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    #2;
    reset       = 1'b1;
    bus.req     = '0;
    bus.last    = '0;
    bus.data_in = '0;
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b0;
    #1;
    chk({tag, " grant"},    32'(bus.grant),       32'h0);
    chk({tag, " ack"},      32'(bus.ack),         32'h0);
    chk({tag, " tx_start"}, 32'(bus.tx_start),    32'h0);
    chk({tag, " tx_byte"},  32'(bus.tx_byte),     32'h0);
    chk({tag, " owner_id"}, 32'(bus.owner_id),    32'h0);
    chk({tag, " timeout"},  32'(bus.timeout_err), 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    int   ord[5];
    int   c;
    int   cnt;
    string tag;

    // Single-byte grant, gap length, withdrawn-free regrant with rr wrap, busy hold in LOAD.
    tbl[0]  = '{4'b0010, 4'b0010, 32'h0000_A500, 1'b0, 1'b0, 1,  4'b0010, 4'b0000, 1'b0, 8'h00, 2'd1};
    tbl[1]  = '{4'b0010, 4'b0010, 32'h0000_A500, 1'b0, 1'b0, 1,  4'b0010, 4'b0010, 1'b1, 8'hA5, 2'd1};
    tbl[2]  = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 3,  4'b0010, 4'b0000, 1'b0, 8'h00, 2'd1};
    tbl[3]  = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b1, 1,  4'b0000, 4'b0000, 1'b0, 8'h00, 2'd1};
    tbl[4]  = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 31, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd1};
    tbl[5]  = '{4'b0001, 4'b0001, 32'h0000_003C, 1'b1, 1'b1, 1,  4'b0000, 4'b0000, 1'b0, 8'h00, 2'd1};
    tbl[6]  = '{4'b0001, 4'b0001, 32'h0000_003C, 1'b1, 1'b1, 1,  4'b0001, 4'b0000, 1'b0, 8'h00, 2'd0};
    tbl[7]  = '{4'b0001, 4'b0001, 32'h0000_003C, 1'b1, 1'b0, 10, 4'b0001, 4'b0000, 1'b0, 8'h00, 2'd0};
    tbl[8]  = '{4'b0001, 4'b0001, 32'h0000_003C, 1'b0, 1'b0, 1,  4'b0001, 4'b0001, 1'b1, 8'h3C, 2'd0};
    tbl[9]  = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 1,  4'b0001, 4'b0000, 1'b0, 8'h00, 2'd0};
    tbl[10] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b1, 1,  4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0};

    bus.req = '0; bus.last = '0; bus.data_in = '0; bus.tx_busy = 1'b0; bus.tx_done = 1'b0;
    do_reset("reset");

    for (int i = 0; i < 11; i++) begin
      bus.req     = tbl[i].req;
      bus.last    = tbl[i].last;
      bus.data_in = tbl[i].data;
      bus.tx_busy = tbl[i].busy;
      bus.tx_done = tbl[i].done;
      for (int j = 0; j < tbl[i].n; j++) begin
        @(negedge clk);
        tag = $sformatf("row%0d.%0d", i, j);
        chk({tag, " grant"},    32'(bus.grant),       32'(tbl[i].e_grant));
        chk({tag, " ack"},      32'(bus.ack),         32'(tbl[i].e_ack));
        chk({tag, " tx_start"}, 32'(bus.tx_start),    32'(tbl[i].e_start));
        chk({tag, " owner_id"}, 32'(bus.owner_id),    32'(tbl[i].e_own));
        chk({tag, " timeout"},  32'(bus.timeout_err), 32'h0);
        if (tbl[i].e_start) chk({tag, " tx_byte"}, 32'(bus.tx_byte), 32'(tbl[i].e_byte));
      end
    end
    bus.tx_done = 1'b0;

    // Round robin over four always-pending requesters.
    do_reset("t2 reset");
    bus.req = 4'hF; bus.last = 4'hF; bus.data_in = 32'h4433_2211;
    ord = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      wait_grant($sformatf("t2 grant%0d", k), 60, c);
      // Grant returns 34 cycles after tx_done: 32 in GAP plus the entry and IDLE decision cycles.
      chk($sformatf("t2 grant%0d delay", k), 32'(c), (k == 0) ? 32'd1 : 32'd33);
      chk($sformatf("t2 grant%0d", k), 32'(bus.grant), 32'(1 << ord[k]));
      wait_start($sformatf("t2 start%0d", k), 5, c);
      chk($sformatf("t2 start%0d delay", k), 32'(c), 32'd1);
      chk($sformatf("t2 ack%0d", k), 32'(bus.ack), 32'(1 << ord[k]));
      chk($sformatf("t2 byte%0d", k), 32'(bus.tx_byte), 32'(8'h11 * (ord[k] + 1)));
      finish_frame(20);
      chk($sformatf("t2 released%0d", k), 32'(bus.grant), 32'h0);
    end

    // Six-byte stream from requester 2: burst of 4, gap, then the remaining 2.
    do_reset("t3 reset");
    bus.req = 4'b0100; bus.last = 4'b0000; bus.data_in = 32'h0001_0000;
    wait_grant("t3 grant", 5, c);
    chk("t3 grant", 32'(bus.grant), 32'h4);
    for (int b = 0; b < 6; b++) begin
      wait_start($sformatf("t3 start%0d", b), 80, c);
      chk($sformatf("t3 spacing%0d", b), 32'(c), (b == 4) ? 32'd34 : 32'd1);
      chk($sformatf("t3 byte%0d", b), 32'(bus.tx_byte), 32'(b + 1));
      chk($sformatf("t3 ack%0d", b), 32'(bus.ack), 32'h4);
      if (b < 5) bus.data_in = 32'(b + 2) << 16;
      else       bus.req     = '0;
      finish_frame(5);
      chk($sformatf("t3 grant_after%0d", b), 32'(bus.grant),
          (b == 3 || b == 5) ? 32'h0 : 32'h4);
    end

    // Missing tx_done: timeout pulse, gap, then the next requester.
    do_reset("t5 reset");
    bus.req = 4'b0011; bus.last = 4'b0011; bus.data_in = 32'h0000_BBAA;
    wait_grant("t5 grant", 5, c);
    chk("t5 grant", 32'(bus.grant), 32'h1);
    wait_start("t5 start", 5, c);
    chk("t5 byte", 32'(bus.tx_byte), 32'hAA);
    bus.req = 4'b0010;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!bus.timeout_err && cnt < 300);
    chk("t5 timeout latency", 32'(cnt), 32'd192);
    chk("t5 grant at timeout", 32'(bus.grant), 32'h0);
    @(negedge clk);
    chk("t5 timeout width", 32'(bus.timeout_err), 32'h0);
    wait_grant("t5 next grant", 60, c);
    chk("t5 next grant delay", 32'(c), 32'd32);
    chk("t5 next grant", 32'(bus.grant), 32'h2);

    // Reset mid-frame, then fresh arbitration starting from requester 0.
    do_reset("t6 pre");
    bus.req = 4'b0010; bus.last = 4'b0010; bus.data_in = 32'h0000_5A00;
    wait_grant("t6 grant1", 5, c);
    wait_start("t6 start1", 5, c);
    bus.req = '0; bus.tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6 owner before reset", 32'(bus.owner_id), 32'd1);
    do_reset("t6 midframe");
    bus.req = 4'b1001; bus.last = 4'b1001; bus.data_in = 32'h7700_0066;
    wait_grant("t6 grant a", 5, c);
    chk("t6 grant a delay", 32'(c), 32'd1);
    chk("t6 grant a", 32'(bus.grant), 32'h1);
    wait_start("t6 start a", 5, c);
    chk("t6 byte a", 32'(bus.tx_byte), 32'h66);
    bus.req = 4'b1000;
    finish_frame(5);
    wait_grant("t6 grant b", 60, c);
    chk("t6 grant b", 32'(bus.grant), 32'h8);
    chk("t6 owner b", 32'(bus.owner_id), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
